// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : Receive side of the 7-bit UART link. It recovers frames made
//                of a start bit (0), DATA_BITS data bits sent LSB first, one
//                parity bit and a stop bit (1). The serial line is
//                synchronised, a falling edge arms the receiver, and every bit
//                is sampled at its middle. Each completed frame produces the
//                data word, a one-cycle valid strobe and parity/framing flags.
//  Ports       : clk        - rising-edge clock
//                rst        - synchronous, active-high reset
//                din        - serial line, idle high, asynchronous to clk
//                p_s        - parity select: 1 = even, 0 = odd
//                dout       - last received data word
//                valid      - one-cycle pulse when dout/flags are updated
//                parity_err - parity mismatch on the frame flagged by valid
//                frame_err  - stop bit sampled low on the frame flagged by valid
//                busy       - high from start confirmation to stop-bit sample
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 p_s,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Terminal counts: half a bit (to reach mid start bit) and a full bit.
    localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] c_IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_rx;
    logic                   r_rx_d;
    logic [CW-1:0]          r_baud;
    logic [IW-1:0]          r_idx;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_par;
    logic                   r_ps;
    logic                   w_exp_par;

    // Two-flop synchroniser plus one delay flop for falling-edge detection.
    // All flops reset to 1 so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx    <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= din;
            r_rx    <= r_sync1;
            r_rx_d  <= r_rx;
        end
    end

    // Parity bit the transmitter should have sent for the captured word,
    // using the parity mode frozen at start confirmation.
    assign w_exp_par = r_ps ? (^r_data) : ~(^r_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_par      <= 1'b0;
            r_ps       <= 1'b0;
            dout       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Edge-triggered arming: a line stuck low cannot re-arm.
                    if (r_rx_d && !r_rx) begin
                        r_baud  <= '0;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_baud == c_HALF_LAST) begin
                        if (!r_rx) begin
                            busy    <= 1'b1;
                            r_ps    <= p_s;
                            r_baud  <= '0;
                            r_idx   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_baud == c_BIT_LAST) begin
                        r_baud        <= '0;
                        r_data[r_idx] <= r_rx;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (r_baud == c_BIT_LAST) begin
                        r_baud  <= '0;
                        r_par   <= r_rx;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_STOP: begin
                    // Returning to IDLE at mid stop bit leaves half a bit of
                    // margin for a back-to-back start edge.
                    if (r_baud == c_BIT_LAST) begin
                        r_baud     <= '0;
                        dout       <= r_data;
                        valid      <= 1'b1;
                        parity_err <= (r_par != w_exp_par);
                        frame_err  <= ~r_rx;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
